// File: rtl/regfile_frame_ctrl.sv
// Frame sequencer for sram_2port_bank: one read or write transaction per Bennett frame, timed off clkp rises.
// Optional build macro REG_ZERO_EN hardwires register address 0 to zero.
module regfile_frame_ctrl #(
  parameter int unsigned PHASES  = 10,
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 16,
  parameter int unsigned ADDR_PH = 2,
  parameter int unsigned DATA_PH = 4,
  parameter int unsigned RD_PH   = 6,
  parameter int unsigned WR_PH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PHASES-1:0] clkp,
  input  logic              rd_valid,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic              rd_ready,
  output logic              rd_done,
  output logic [DW-1:0]     rd_data_a,
  output logic [DW-1:0]     rd_data_b,
  input  logic              wr_valid,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  output logic              wr_ready,
  output logic [AW-1:0]     bank_addr_a,
  output logic [AW-1:0]     bank_addr_b,
  output logic [DW-1:0]     bank_din,
  output logic              bank_read_en,
  output logic              bank_write_en,
  input  logic [DW-1:0]     bank_out_a,
  input  logic [DW-1:0]     bank_out_b
);

  localparam int unsigned WEND_PH = WR_PH + 1;

  // Phases later than the one being waited for; a rise there means the stack is out of order.
  localparam logic [PHASES-1:0] ABV_ADDR = {PHASES{1'b1}} << (ADDR_PH + 1);
  localparam logic [PHASES-1:0] ABV_DATA = {PHASES{1'b1}} << (DATA_PH + 1);
  localparam logic [PHASES-1:0] ABV_RD   = {PHASES{1'b1}} << (RD_PH + 1);
  localparam logic [PHASES-1:0] ABV_WR   = {PHASES{1'b1}} << (WR_PH + 1);
  localparam logic [PHASES-1:0] ABV_WEND = {PHASES{1'b1}} << (WEND_PH + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_GRANT, S_SKIP, S_ADDR, S_WDATA, S_WR_WAIT, S_WRITE, S_RD_WAIT, S_READ, S_RETIRE
  } state_t;

  state_t            state_q, state_d;
  logic [PHASES-1:0] clkp_q;
  logic              primed_q;
  logic              rr_wr_first_q, rr_wr_first_d;
  logic              is_wr_q, is_wr_d;
  logic              live_q, live_d;
  logic [AW-1:0]     lat_a_q, lat_a_d;
  logic [AW-1:0]     lat_b_q, lat_b_d;
  logic [DW-1:0]     lat_data_q, lat_data_d;

  logic              rd_ready_d, rd_done_d, wr_ready_d;
  logic [DW-1:0]     rd_data_a_d, rd_data_b_d;
  logic [AW-1:0]     bank_addr_a_d, bank_addr_b_d;
  logic [DW-1:0]     bank_din_d;
  logic              bank_read_en_d, bank_write_en_d;

  logic [PHASES-1:0] rise_c, fall_c;
  logic              zero_a_c, zero_b_c;

  // The first sample after reset only primes clkp_q, so a frame already in flight is never seen as a rise.
  assign rise_c = primed_q ? (clkp & ~clkp_q) : '0;
  assign fall_c = primed_q ? (~clkp & clkp_q) : '0;

`ifdef REG_ZERO_EN
  assign zero_a_c = (lat_a_q == '0);
  assign zero_b_c = (lat_b_q == '0);
`else
  assign zero_a_c = 1'b0;
  assign zero_b_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      clkp_q        <= '0;
      primed_q      <= 1'b0;
      rr_wr_first_q <= 1'b1;
      is_wr_q       <= 1'b0;
      live_q        <= 1'b0;
      lat_a_q       <= '0;
      lat_b_q       <= '0;
      lat_data_q    <= '0;
      rd_ready      <= 1'b0;
      rd_done       <= 1'b0;
      wr_ready      <= 1'b0;
      rd_data_a     <= '0;
      rd_data_b     <= '0;
      bank_addr_a   <= '0;
      bank_addr_b   <= '0;
      bank_din      <= '0;
      bank_read_en  <= 1'b0;
      bank_write_en <= 1'b0;
    end else begin
      state_q       <= state_d;
      clkp_q        <= clkp;
      primed_q      <= 1'b1;
      rr_wr_first_q <= rr_wr_first_d;
      is_wr_q       <= is_wr_d;
      live_q        <= live_d;
      lat_a_q       <= lat_a_d;
      lat_b_q       <= lat_b_d;
      lat_data_q    <= lat_data_d;
      rd_ready      <= rd_ready_d;
      rd_done       <= rd_done_d;
      wr_ready      <= wr_ready_d;
      rd_data_a     <= rd_data_a_d;
      rd_data_b     <= rd_data_b_d;
      bank_addr_a   <= bank_addr_a_d;
      bank_addr_b   <= bank_addr_b_d;
      bank_din      <= bank_din_d;
      bank_read_en  <= bank_read_en_d;
      bank_write_en <= bank_write_en_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_wr_first_d   = rr_wr_first_q;
    is_wr_d         = is_wr_q;
    live_d          = live_q;
    lat_a_d         = lat_a_q;
    lat_b_d         = lat_b_q;
    lat_data_d      = lat_data_q;
    rd_ready_d      = 1'b0;
    rd_done_d       = 1'b0;
    wr_ready_d      = 1'b0;
    rd_data_a_d     = rd_data_a;
    rd_data_b_d     = rd_data_b;
    bank_addr_a_d   = bank_addr_a;
    bank_addr_b_d   = bank_addr_b;
    bank_din_d      = bank_din;
    bank_read_en_d  = bank_read_en;
    bank_write_en_d = bank_write_en;

    // End of frame closes out whatever is in flight and clears the bank buses.
    if (fall_c[0] && state_q != S_IDLE) begin
      state_d         = S_IDLE;
      bank_addr_a_d   = '0;
      bank_addr_b_d   = '0;
      bank_din_d      = '0;
      bank_read_en_d  = 1'b0;
      bank_write_en_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise_c[0]) begin
            state_d = S_GRANT;
            live_d  = 1'b1;
            if (wr_valid && (!rd_valid || rr_wr_first_q)) begin
              wr_ready_d    = 1'b1;
              is_wr_d       = 1'b1;
              lat_a_d       = wr_addr;
              lat_b_d       = '0;
              lat_data_d    = wr_data;
              rr_wr_first_d = 1'b0;
            end else if (rd_valid) begin
              rd_ready_d    = 1'b1;
              is_wr_d       = 1'b0;
              lat_a_d       = rd_addr_a;
              lat_b_d       = rd_addr_b;
              lat_data_d    = '0;
              rr_wr_first_d = 1'b1;
            end else begin
              live_d = 1'b0;
            end
          end
        end
        S_GRANT: state_d = live_q ? S_ADDR : S_SKIP;
        S_ADDR: begin
          if (rise_c[ADDR_PH]) begin
            bank_addr_a_d = lat_a_q;
            bank_addr_b_d = lat_b_q;
            state_d       = is_wr_q ? S_WDATA : S_RD_WAIT;
          end else if (|(rise_c & ABV_ADDR)) begin
            state_d = S_SKIP;
          end
        end
        S_WDATA: begin
          if (rise_c[DATA_PH]) begin
            bank_din_d = lat_data_q;
            state_d    = S_WR_WAIT;
          end else if (|(rise_c & ABV_DATA)) begin
            state_d = S_SKIP;
          end
        end
        S_WR_WAIT: begin
          if (rise_c[WR_PH]) begin
            bank_write_en_d = ~zero_a_c;
            state_d         = S_WRITE;
          end else if (|(rise_c & ABV_WR)) begin
            state_d = S_SKIP;
          end
        end
        S_WRITE: begin
          if (rise_c[WEND_PH]) begin
            bank_write_en_d = 1'b0;
            state_d         = S_RETIRE;
          end else if (|(rise_c & ABV_WEND)) begin
            bank_write_en_d = 1'b0;
            state_d         = S_SKIP;
          end
        end
        S_RD_WAIT: begin
          if (rise_c[RD_PH]) begin
            bank_read_en_d = 1'b1;
            state_d        = S_READ;
          end else if (|(rise_c & ABV_RD)) begin
            state_d = S_SKIP;
          end
        end
        S_READ: begin
          if (rise_c[WR_PH]) begin
            bank_read_en_d = 1'b0;
            rd_data_a_d    = zero_a_c ? '0 : bank_out_a;
            rd_data_b_d    = zero_b_c ? '0 : bank_out_b;
            rd_done_d      = 1'b1;
            state_d        = S_RETIRE;
          end else if (|(rise_c & ABV_WR)) begin
            bank_read_en_d = 1'b0;
            state_d        = S_SKIP;
          end
        end
        S_SKIP, S_RETIRE: state_d = state_q;
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_frame_ctrl.sv
// Directed bench for regfile_frame_ctrl: handshake scoreboard plus per-phase bank bus checks.
// Expectations for address-0 behaviour follow the REG_ZERO_EN build macro.
module tb_regfile_frame_ctrl;

  localparam int unsigned PHASES = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  clkp;
  logic        rd_valid, wr_valid;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] wr_data;
  logic        rd_ready, rd_done, wr_ready;
  logic [15:0] rd_data_a, rd_data_b;
  logic [4:0]  bank_addr_a, bank_addr_b;
  logic [15:0] bank_din;
  logic        bank_read_en, bank_write_en;
  logic [15:0] bank_out_a, bank_out_b;

  int n_assert = 0;
  int n_fail   = 0;
  bit hold_reqs = 1'b0;

  typedef struct {
    int          kind;   // 1 wr_ready, 2 rd_ready, 3 rd_done
    logic [15:0] a;
    logic [15:0] b;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  int  mon_act;

  regfile_frame_ctrl dut (
    .clk(clk), .reset(reset), .clkp(clkp),
    .rd_valid(rd_valid), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_ready(rd_ready), .rd_done(rd_done), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .bank_addr_a(bank_addr_a), .bank_addr_b(bank_addr_b), .bank_din(bank_din),
    .bank_read_en(bank_read_en), .bank_write_en(bank_write_en),
    .bank_out_a(bank_out_a), .bank_out_b(bank_out_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input int kind, input logic [15:0] a, input logic [15:0] b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    return e;
  endfunction

  // Handshake monitor: every ready/done pulse must match the next expected event.
  always @(negedge clk) begin
    if (wr_ready || rd_ready || rd_done) begin
      mon_act = wr_ready ? 1 : (rd_ready ? 2 : 3);
      if (exp_q.size() == 0) begin
        chk("unexpected handshake", 64'(mon_act), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("handshake kind", 64'(mon_act), 64'(mon_e.kind));
        if (mon_act == 3)
          chk("rd_data at rd_done", 64'({rd_data_a, rd_data_b}), 64'({mon_e.a, mon_e.b}));
      end
    end
    if (bank_read_en || bank_write_en)
      chk("read_en/write_en overlap", 64'(bank_read_en & bank_write_en), 64'(0));
  end

  function automatic logic [63:0] bank_snap();
    return 64'({bank_addr_a, bank_addr_b, bank_din, bank_read_en, bank_write_en});
  endfunction

  function automatic logic [63:0] bank_exp(input logic [4:0] a, input logic [4:0] b,
                                           input logic [15:0] d, input logic re, input logic we);
    return 64'({a, b, d, re, we});
  endfunction

  // kind: 0 none, 1 write, 2 read. rst_at: phase after whose rise reset pulses. late_rd_at: phase at which rd_valid rises.
  task automatic frame(input int kind, input logic [4:0] ea, input logic [4:0] eb, input logic [15:0] ed,
                       input logic we_exp, input logic [15:0] da, input logic [15:0] db,
                       input int rst_at, input int late_rd_at);
    int k;
    k = kind;
    if (kind == 1) exp_q.push_back(mk(1, 16'h0, 16'h0));
    if (kind == 2) exp_q.push_back(mk(2, 16'h0, 16'h0));
    if (kind == 2 && rst_at < 0) exp_q.push_back(mk(3, da, db));
    for (int p = 0; p < PHASES; p++) begin
      @(negedge clk);
      clkp[p] = 1'b1;
      @(negedge clk);
      if (p == 0 && !hold_reqs) begin
        if (rd_ready) rd_valid = 1'b0;
        if (wr_ready) wr_valid = 1'b0;
      end
      if (p == late_rd_at) rd_valid = 1'b1;
      chk($sformatf("bank bus after rise %0d", p), bank_snap(),
          bank_exp((k != 0 && p >= 2) ? ea : 5'd0, (k != 0 && p >= 2) ? eb : 5'd0,
                   (k == 1 && p >= 4) ? ed : 16'd0,
                   (k == 2 && p >= 6 && p < 8), (k == 1 && we_exp && p == 8)));
      if (p == rst_at) begin
        #3 reset = 1'b0;
        #1 chk("outputs during mid-frame reset",
               64'({rd_ready, rd_done, wr_ready, rd_data_a, rd_data_b, bank_read_en, bank_write_en}),
               64'(0));
        chk("bank bus during mid-frame reset", bank_snap(), 64'(0));
        k = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
      end
      @(negedge clk);
    end
    for (int p = PHASES - 1; p >= 0; p--) begin
      @(negedge clk);
      clkp[p] = 1'b0;
      @(negedge clk);
      chk($sformatf("bank bus after fall %0d", p), bank_snap(),
          bank_exp((k != 0 && p > 0) ? ea : 5'd0, (k != 0 && p > 0) ? eb : 5'd0,
                   (k == 1 && p > 0) ? ed : 16'd0, 1'b0, 1'b0));
    end
    if (kind == 2 && rst_at < 0)
      chk("rd_data held after frame", 64'({rd_data_a, rd_data_b}), 64'({da, db}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; clkp = '0;
    rd_valid = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    bank_out_a = '0; bank_out_b = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", 64'({rd_ready, rd_done, wr_ready, rd_data_a, rd_data_b}), 64'(0));
    chk("reset bank bus", bank_snap(), 64'(0));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single write.
    wr_valid = 1'b1; wr_addr = 5'd1; wr_data = 16'hAAAA;
    frame(1, 5'd1, 5'd0, 16'hAAAA, 1'b1, 16'h0, 16'h0, -1, -1);

    // Single read.
    rd_valid = 1'b1; rd_addr_a = 5'd1; rd_addr_b = 5'd2;
    bank_out_a = 16'hAAAA; bank_out_b = 16'h5555;
    frame(2, 5'd1, 5'd2, 16'h0, 1'b0, 16'hAAAA, 16'h5555, -1, -1);

    // Empty frame; a read raised after the grant cycle is served in the following frame.
    rd_addr_a = 5'd3; rd_addr_b = 5'd4;
    frame(0, 5'd0, 5'd0, 16'h0, 1'b0, 16'h0, 16'h0, -1, 3);
    bank_out_a = 16'h1357; bank_out_b = 16'h2468;
    frame(2, 5'd3, 5'd4, 16'h0, 1'b0, 16'h1357, 16'h2468, -1, -1);

    // Reset during an active read_en window: transaction lost, rest of that frame ignored.
    rd_valid = 1'b1; rd_addr_a = 5'd7; rd_addr_b = 5'd8;
    frame(2, 5'd7, 5'd8, 16'h0, 1'b0, 16'h0, 16'h0, 6, -1);
    chk("rd_data cleared by reset", 64'({rd_data_a, rd_data_b}), 64'(0));

    // Both pending from reset: write first, then alternate.
    hold_reqs = 1'b1;
    rd_valid = 1'b1; rd_addr_a = 5'd9; rd_addr_b = 5'd10;
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 16'h1234;
    bank_out_a = 16'h0F0F; bank_out_b = 16'hF0F0;
    frame(1, 5'd5, 5'd0, 16'h1234, 1'b1, 16'h0, 16'h0, -1, -1);
    frame(2, 5'd9, 5'd10, 16'h0, 1'b0, 16'h0F0F, 16'hF0F0, -1, -1);
    frame(1, 5'd5, 5'd0, 16'h1234, 1'b1, 16'h0, 16'h0, -1, -1);
    hold_reqs = 1'b0;
    rd_valid = 1'b0; wr_valid = 1'b0;
    frame(0, 5'd0, 5'd0, 16'h0, 1'b0, 16'h0, 16'h0, -1, -1);

    // Address 0 handling.
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 16'hBEEF;
    rd_addr_a = 5'd0; rd_addr_b = 5'd1;
    bank_out_a = 16'h1111; bank_out_b = 16'h2222;
`ifdef REG_ZERO_EN
    frame(1, 5'd0, 5'd0, 16'hBEEF, 1'b0, 16'h0, 16'h0, -1, -1);
    rd_valid = 1'b1;
    frame(2, 5'd0, 5'd1, 16'h0, 1'b0, 16'h0000, 16'h2222, -1, -1);
`else
    frame(1, 5'd0, 5'd0, 16'hBEEF, 1'b1, 16'h0, 16'h0, -1, -1);
    rd_valid = 1'b1;
    frame(2, 5'd0, 5'd1, 16'h0, 1'b0, 16'h1111, 16'h2222, -1, -1);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
